// File: rtl/qed_mem_responder.sv
// Memory-side responder for the picorv32 native memory interface: free-input
// instruction fetches, a small data array for loads/stores, programmable wait states.
module qed_mem_responder #(
    parameter int LATENCY_MAX = 3,
    parameter int DEPTH       = 16,
    parameter int CNT_W       = 16,
    localparam int WAIT_W     = $clog2(LATENCY_MAX + 1),
    localparam int IDX_W      = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              mem_valid,
    input  logic              mem_instr,
    input  logic [31:0]       mem_addr,
    input  logic [31:0]       mem_wdata,
    input  logic [3:0]        mem_wstrb,
    output logic              mem_ready,
    output logic [31:0]       mem_rdata,
    input  logic [31:0]       instr_in,
    input  logic [WAIT_W-1:0] wait_in,
    output logic [CNT_W-1:0]  fetch_count,
    output logic              proto_err
);

    // state  | meaning
    // S_IDLE | waiting for mem_valid; accepts and latches the request
    // S_WAIT | counting down wait states
    // S_RESP | mem_ready high for this single cycle
    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    localparam int unsigned LMAX = LATENCY_MAX;

    state_t            state;
    logic [WAIT_W-1:0] cnt;
    logic [31:0]       lat_addr;
    logic [31:0]       lat_wdata;
    logic [3:0]        lat_wstrb;
    logic              lat_instr;
    logic [31:0]       mem [DEPTH];

    logic [31:0]       wait_ext;
    logic [WAIT_W-1:0] wait_ld;
    logic [31:0]       cur_addr;
    logic [31:0]       cur_wdata;
    logic [3:0]        cur_wstrb;
    logic              cur_instr;
    logic [IDX_W-1:0]  cur_idx;
    logic [31:0]       merged;
    logic [31:0]       resp_data;
    logic              go_resp;
    logic              is_fetch;
    logic              violation;

    // Compare in 32 bits so the clamp stays meaningful for any LATENCY_MAX.
    assign wait_ext = 32'(wait_in);
    assign wait_ld  = (wait_ext > LMAX) ? WAIT_W'(LMAX) : wait_in;

    // A zero-wait accept goes straight to RESP, so the response is built
    // from the live inputs rather than the not-yet-written latches.
    always_comb begin
        if (state == S_IDLE) begin
            cur_addr  = mem_addr;
            cur_wdata = mem_wdata;
            cur_wstrb = mem_wstrb;
            cur_instr = mem_instr;
        end else begin
            cur_addr  = lat_addr;
            cur_wdata = lat_wdata;
            cur_wstrb = lat_wstrb;
            cur_instr = lat_instr;
        end
    end

    assign cur_idx  = cur_addr[IDX_W+1:2];
    assign is_fetch = cur_instr && (cur_wstrb == 4'h0);

    always_comb begin
        merged = mem[cur_idx];
        for (int k = 0; k < 4; k++) begin
            if (cur_wstrb[k]) merged[8*k +: 8] = cur_wdata[8*k +: 8];
        end
    end

    always_comb begin
        if (cur_wstrb != 4'h0) resp_data = 32'h0;
        else if (cur_instr)    resp_data = instr_in;
        else                   resp_data = mem[cur_idx];
    end

    assign go_resp = ((state == S_IDLE) && mem_valid && (wait_ld == '0)) ||
                     ((state == S_WAIT) && (cnt == WAIT_W'(1)));

    assign violation = ((state == S_WAIT) || (state == S_RESP)) &&
                       (!mem_valid || (mem_addr != lat_addr) || (mem_wstrb != lat_wstrb) ||
                        (mem_instr != lat_instr) || (mem_wdata != lat_wdata));

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state       <= S_IDLE;
            cnt         <= '0;
            lat_addr    <= '0;
            lat_wdata   <= '0;
            lat_wstrb   <= '0;
            lat_instr   <= 1'b0;
            mem_ready   <= 1'b0;
            mem_rdata   <= '0;
            fetch_count <= '0;
            proto_err   <= 1'b0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            mem_ready <= go_resp;
            if (violation) proto_err <= 1'b1;

            // Everything the response produces lands on the edge into RESP.
            if (go_resp) begin
                mem_rdata <= resp_data;
                if (cur_wstrb != 4'h0) mem[cur_idx] <= merged;
                if (is_fetch && (fetch_count != '1)) fetch_count <= fetch_count + CNT_W'(1);
            end

            case (state)
                S_IDLE: begin
                    if (mem_valid) begin
                        lat_addr  <= mem_addr;
                        lat_wdata <= mem_wdata;
                        lat_wstrb <= mem_wstrb;
                        lat_instr <= mem_instr;
                        cnt       <= wait_ld;
                        state     <= (wait_ld == '0) ? S_RESP : S_WAIT;
                    end
                end
                S_WAIT: begin
                    cnt <= cnt - WAIT_W'(1);
                    if (cnt == WAIT_W'(1)) state <= S_RESP;
                end
                S_RESP:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_qed_mem_responder.sv
// Directed bench for qed_mem_responder: vector table of transactions plus
// hand-written sequences for protocol errors, reset mid-request and counter saturation.
module tb_qed_mem_responder;

    logic        clk = 1'b0;
    logic        resetn;
    logic        mem_valid;
    logic        mem_instr;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic [31:0] instr_in;
    logic [1:0]  wait_in;
    logic [15:0] fetch_count;
    logic        proto_err;

    logic        s_ready;
    logic [31:0] s_rdata;
    logic [2:0]  s_count;
    logic        s_err;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    qed_mem_responder dut (
        .clk(clk), .resetn(resetn), .mem_valid(mem_valid), .mem_instr(mem_instr),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata), .instr_in(instr_in),
        .wait_in(wait_in), .fetch_count(fetch_count), .proto_err(proto_err)
    );

    // Narrow counter copy on the same bus, used to reach saturation quickly.
    qed_mem_responder #(.CNT_W(3)) u_sat (
        .clk(clk), .resetn(resetn), .mem_valid(mem_valid), .mem_instr(mem_instr),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
        .mem_ready(s_ready), .mem_rdata(s_rdata), .instr_in(instr_in),
        .wait_in(wait_in), .fetch_count(s_count), .proto_err(s_err)
    );

    typedef struct {
        logic        instr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        int          wt;
        logic [31:0] iw;
        logic [31:0] exp_rdata;
        int          exp_lat;
        logic [15:0] exp_fc;
    } vec_t;

    vec_t vecs[11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Called #1 after an edge with the DUT idle; returns #1 after the RESP cycle ends.
    task automatic do_txn(input logic instr, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] wstrb, input int wt, input logic [31:0] iw,
                          output logic [31:0] rdata, output int lat, output logic [15:0] fc,
                          output logic ready_after);
        logic seen;
        mem_valid = 1'b1;
        mem_instr = instr;
        mem_addr  = addr;
        mem_wdata = wdata;
        mem_wstrb = wstrb;
        wait_in   = 2'(wt);
        instr_in  = iw;
        lat  = 0;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(posedge clk); #1;
            lat++;
            if (mem_ready) seen = 1'b1;
        end
        if (!seen) check("ready_timeout", 32'(seen), 32'd1);
        rdata = mem_rdata;
        fc    = fetch_count;
        @(posedge clk); #1;
        ready_after = mem_ready;
        mem_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        int          lat;
        logic [15:0] fc;
        logic        rdy_after;
        logic        ready_any;

        // wait 7 on a 2-bit port arrives as 3, which is also LATENCY_MAX.
        vecs[0]  = '{1'b1, 32'h0000_0000, 32'h0,         4'h0, 0, 32'h0000_0013, 32'h0000_0013, 1, 16'd1};
        vecs[1]  = '{1'b0, 32'h0000_0008, 32'hDEAD_BEEF, 4'hF, 0, 32'h0,         32'h0,         1, 16'd1};
        vecs[2]  = '{1'b0, 32'h0000_0008, 32'h0000_0055, 4'h1, 1, 32'h0,         32'h0,         2, 16'd1};
        vecs[3]  = '{1'b0, 32'h0000_0008, 32'h0,         4'h0, 2, 32'h0,         32'hDEAD_BE55, 3, 16'd1};
        vecs[4]  = '{1'b1, 32'h0000_0004, 32'h0,         4'h0, 7, 32'h0010_0093, 32'h0010_0093, 4, 16'd2};
        vecs[5]  = '{1'b0, 32'h0000_0048, 32'h0,         4'h0, 0, 32'hFFFF_FFFF, 32'hDEAD_BE55, 1, 16'd2};
        vecs[6]  = '{1'b0, 32'h0000_003C, 32'h1122_3344, 4'hA, 1, 32'h0,         32'h0,         2, 16'd2};
        vecs[7]  = '{1'b0, 32'h0000_003E, 32'h0,         4'h0, 0, 32'h0,         32'h1100_3300, 1, 16'd2};
        vecs[8]  = '{1'b0, 32'h0000_0008, 32'hAABB_CCDD, 4'h6, 3, 32'h0,         32'h0,         4, 16'd2};
        vecs[9]  = '{1'b0, 32'h8000_0008, 32'h0,         4'h0, 1, 32'h0,         32'hDEBB_CC55, 2, 16'd2};
        vecs[10] = '{1'b0, 32'h0000_0000, 32'h0,         4'h0, 0, 32'h0,         32'h0,         1, 16'd2};

        resetn = 1'b0; mem_valid = 1'b0; mem_instr = 1'b0; mem_addr = '0;
        mem_wdata = '0; mem_wstrb = '0; instr_in = '0; wait_in = '0;
        #1;
        check("reset_ready", 32'(mem_ready), 32'd0);
        check("reset_rdata", mem_rdata, 32'd0);
        check("reset_fcount", 32'(fetch_count), 32'd0);
        check("reset_proto", 32'(proto_err), 32'd0);
        repeat (2) @(posedge clk);
        #1 resetn = 1'b1;

        for (int v = 0; v < 11; v++) begin
            do_txn(vecs[v].instr, vecs[v].addr, vecs[v].wdata, vecs[v].wstrb, vecs[v].wt,
                   vecs[v].iw, rd, lat, fc, rdy_after);
            check($sformatf("v%0d_rdata", v), rd, vecs[v].exp_rdata);
            check($sformatf("v%0d_latency", v), 32'(lat), 32'(vecs[v].exp_lat));
            check($sformatf("v%0d_fcount", v), 32'(fc), 32'(vecs[v].exp_fc));
            check($sformatf("v%0d_ready_one_cycle", v), 32'(rdy_after), 32'd0);
            check($sformatf("v%0d_proto", v), 32'(proto_err), 32'd0);
        end

        // mem_valid dropped during WAIT: error next cycle, response still completes.
        mem_valid = 1'b1; mem_instr = 1'b0; mem_addr = 32'h8; mem_wstrb = 4'h0;
        mem_wdata = 32'h0; wait_in = 2'd2;
        @(posedge clk); #1;
        check("perr_before", 32'(proto_err), 32'd0);
        mem_valid = 1'b0;
        @(posedge clk); #1;
        check("perr_set", 32'(proto_err), 32'd1);
        check("perr_no_ready_yet", 32'(mem_ready), 32'd0);
        @(posedge clk); #1;
        check("perr_resp_ready", 32'(mem_ready), 32'd1);
        check("perr_resp_rdata", mem_rdata, 32'hDEBB_CC55);
        repeat (3) @(posedge clk);
        #1;
        check("perr_sticky", 32'(proto_err), 32'd1);
        check("perr_ready_low", 32'(mem_ready), 32'd0);
        resetn = 1'b0;
        #1;
        check("perr_cleared", 32'(proto_err), 32'd0);
        check("reset2_fcount", 32'(fetch_count), 32'd0);
        check("reset2_rdata", mem_rdata, 32'd0);
        @(posedge clk); #1 resetn = 1'b1;

        // Reset in the middle of a store's wait states.
        mem_valid = 1'b1; mem_instr = 1'b0; mem_addr = 32'h4; mem_wstrb = 4'hF;
        mem_wdata = 32'h1234_5678; wait_in = 2'd3;
        @(posedge clk); #1;
        @(posedge clk); #1;
        ready_any = mem_ready;
        resetn = 1'b0; mem_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            ready_any = ready_any | mem_ready;
        end
        check("rstwait_no_ready", 32'(ready_any), 32'd0);
        resetn = 1'b1;
        do_txn(1'b0, 32'h4, 32'h0, 4'h0, 0, 32'h0, rd, lat, fc, rdy_after);
        check("rstwait_load_rdata", rd, 32'd0);
        check("rstwait_load_latency", 32'(lat), 32'd1);

        // Fetch counter saturation (3-bit copy saturates at 7).
        for (int i = 0; i < 6; i++)
            do_txn(1'b1, 32'(4 * i), 32'h0, 4'h0, 0, 32'h13, rd, lat, fc, rdy_after);
        check("sat_pre", 32'(s_count), 32'd6);
        do_txn(1'b1, 32'h40, 32'h0, 4'h0, 0, 32'h13, rd, lat, fc, rdy_after);
        check("sat_reach", 32'(s_count), 32'd7);
        check("main_count7", 32'(fetch_count), 32'd7);
        do_txn(1'b1, 32'h44, 32'h0, 4'h0, 0, 32'h13, rd, lat, fc, rdy_after);
        check("sat_hold", 32'(s_count), 32'd7);
        check("main_count8", 32'(fetch_count), 32'd8);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/qed_mem_responder.md
# qed_mem_responder

Memory-side responder for the picorv32 native memory interface in the QED formal and simulation harness. It sits between `design_top.dut` and the environment and answers every fetch, load and store the core issues, with a programmable number of wait states. Instruction words come from a free input, so the formal tool or a bench can drive arbitrary, QED-transformed instruction streams. Stores and loads hit a small internal data array, and a sticky error flag reports initiator-side protocol violations.

## Interface
Parameters:
- `LATENCY_MAX`, default 3: maximum wait states inserted before `mem_ready`.
- `DEPTH`, default 16: number of 32-bit words in the data array, power of two; index is `mem_addr[$clog2(DEPTH)+1:2]`.
- `CNT_W`, default 16: width of the fetch counter.

Ports:
- `clk` in 1: single clock, rising edge.
- `resetn` in 1: reset, asynchronous, active-low.
- `mem_valid` in 1: request valid from the core.
- `mem_instr` in 1: request is an instruction fetch.
- `mem_addr` in 32: byte address.
- `mem_wdata` in 32: store data.
- `mem_wstrb` in 4: byte write strobes; 0 means read.
- `mem_ready` out 1: single-cycle response strobe.
- `mem_rdata` out 32: read data, registered.
- `instr_in` in 32: instruction word to deliver on fetches.
- `wait_in` in `$clog2(LATENCY_MAX+1)`: requested wait states, sampled at accept.
- `fetch_count` out `CNT_W`: number of fetches delivered.
- `proto_err` out 1: sticky protocol-violation flag.

## Operation
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - If `mem_valid`=1, accept the request.
  - Latch `mem_addr`, `mem_wdata`, `mem_wstrb` and `mem_instr`.
  - Load the wait counter with `min(wait_in, LATENCY_MAX)`.
  - Go to RESP if the loaded value is 0, else go to WAIT.
- WAIT: decrement the counter each cycle; go to RESP when it reaches 0 after the decrement.
- RESP:
  - `mem_ready`=1 for exactly this cycle, then return to IDLE.
  - No request is accepted in the RESP cycle.
- Response data, loaded into the `mem_rdata` register on the transition into RESP:
  - Fetch (`mem_instr`=1, `wstrb`=0): `instr_in` as sampled on that transition edge.
  - Load (`mem_instr`=0, `wstrb`=0): `array[idx]`.
  - Store (`wstrb`≠0): 0.
- Store commit:
  - The array is written on the same transition edge.
  - Byte lane k is written from `wdata[8k+7:8k]` only where `wstrb[k]`=1.
  - A load that follows a store to the same index returns the merged word.
- Address decode:
  - Only the index bits are decoded; higher address bits alias.
  - `addr[1:0]` is ignored; the core always issues word-aligned requests.
- `fetch_count`:
  - Increments by 1 in each RESP cycle of a fetch.
  - Saturates at all-ones, with no wrap.
- `proto_err`:
  - Set in the cycle after any WAIT or RESP cycle in which `mem_valid`=0, or in which `mem_addr`, `mem_wstrb`, `mem_instr` or `mem_wdata` differ from the latched values.
  - Once set, clears only on reset.
  - The response still completes normally.
- Simultaneous events:
  - When a request is accepted in IDLE, all four inputs are latched in that same cycle.
  - If `mem_valid` is still high in the IDLE cycle after RESP, it is treated as a new request.

## Timing
- Reset values (asynchronous assert):
  - state IDLE, `mem_ready`=0, `mem_rdata`=0, `fetch_count`=0, `proto_err`=0.
  - Wait counter 0, latches 0, all array words 0.
- Reset is removed synchronously to `clk` by the environment. The first accept can happen on the first rising edge with `resetn`=1.
- Reset during WAIT or RESP: the pending request is dropped and no array write occurs unless the write edge has already passed.
- Latency:
  - Accept at edge T gives `mem_ready` high during cycle T+1+w, where w is the clamped wait value.
  - With w=0, `mem_ready` is high in cycle T+1.
- Throughput: back-to-back requests give at most one response every 2+w cycles.
- `mem_rdata` is stable from the RESP cycle until the next RESP cycle.

## Test plan
- Reset, then fetch at 0x0000_0000 with `wait_in`=0 and `instr_in`=0x0000_0013:
  - `mem_ready` is high exactly 1 cycle after accept.
  - `mem_rdata`=0x0000_0013 and `fetch_count`=1.
- Store 0xDEAD_BEEF to 0x8 with `wstrb`=0xF, then store 0x0000_0055 with `wstrb`=0x1, then load 0x8:
  - The load returns 0xDEAD_BE55.
  - The load with `wait_in`=2 raises `mem_ready` 3 cycles after accept.
- `wait_in`=7 with `LATENCY_MAX`=3: `mem_ready` is high 4 cycles after accept (clamped).
- Drop `mem_valid` during WAIT:
  - `proto_err`=1 the next cycle and stays 1.
  - The response still arrives; `proto_err` clears only on `resetn`=0.
- Assert `resetn`=0 during WAIT of a store to 0x4:
  - `mem_ready` never pulses.
  - A load from 0x4 after reset returns 0.
- Force `fetch_count` to all-ones−1 with two more fetches: `fetch_count` saturates at 0xFFFF.
